// File: rtl/spi_target_if.sv
// spi_target_if: CPU-side memory-mapped bus for the SPI target.
// The slave modport is used by spi_target; the master modport by whatever drives the bus.
interface spi_target_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        ready_out;

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );
endinterface

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with a small RX FIFO and a single TX holding byte.
// SCLK/MOSI/CS are oversampled by clk through a synchronizer chain plus a history flop.
// Register map: 0x0 RX_DATA (R, pops), 0x4 TX_DATA (W), 0x8 STATUS (R), 0xC CTRL (W1C flags).
// Optional macro SPI_TARGET_IRQ_EN adds irq_out and the CTRL[3:2] interrupt enables.
module spi_target #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  spi_target_if.slave bus,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso
`ifdef SPI_TARGET_IRQ_EN
  ,
  output logic       irq_out
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [FIFO_AW:0]   FULL_COUNT = FIFO_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CNT_ONE    = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE    = 1;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr;
  logic sclk_prev, cs_prev;
  logic sclk_sync, mosi_sync, cs_sync;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic load_tx, shift_tx, sample_rx, end_xfer;
  logic [7:0] tx_shift, rx_shift, push_data, tx_hold;
  logic [2:0] bit_cnt;
  logic push_pending, tx_full, rx_overrun, tx_underrun;

  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic fifo_empty, fifo_full, push_ok, overrun_evt, pop;
  logic rx_valid, rx_full, active;
  logic [7:0] rx_head;

  logic [3:0]  offset;
  logic rd_sel, wr_sel, rx_rd, rx_rd_prev, tx_wr, ctrl_wr;
  logic [31:0] read_value;
  logic unused_bits;

`ifdef SPI_TARGET_IRQ_EN
  logic [1:0] ctrl_en;
`endif

  assign sclk_sync = sclk_sr[SYNC_STAGES-1];
  assign mosi_sync = mosi_sr[SYNC_STAGES-1];
  assign cs_sync   = cs_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign cs_fall   = ~cs_sync & cs_prev;
  assign cs_rise   = cs_sync & ~cs_prev;

  assign offset  = bus.address_in[3:0];
  assign rd_sel  = bus.sel_in & bus.read_in;
  assign wr_sel  = bus.sel_in & (|bus.write_mask_in);
  assign rx_rd   = rd_sel & (offset == 4'h0);
  assign tx_wr   = wr_sel & (offset == 4'h4);
  assign ctrl_wr = wr_sel & (offset == 4'hC);

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == FULL_COUNT);
  assign pop         = rx_rd & ~rx_rd_prev & ~fifo_empty;
  assign push_ok     = push_pending & (~fifo_full | pop);
  assign overrun_evt = push_pending & fifo_full & ~pop;
  assign rx_valid    = ~fifo_empty;
  assign rx_full     = fifo_full;
  assign active      = (state == ACTIVE);
  assign rx_head     = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  assign unused_bits = ^{bus.address_in[31:4], bus.write_value_in[31:8]};

  // Pin synchronizers plus one history flop per signal for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sr   <= '0;
      mosi_sr   <= '0;
      cs_sr     <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], spi_clk};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_sync;
      cs_prev   <= cs_sync;
    end
  end

  // Transfer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and shifter control; CS rise takes priority over any SCLK edge.
  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    sample_rx  = 1'b0;
    end_xfer   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          load_tx    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          end_xfer   = 1'b1;
        end else begin
          if (sclk_rise) sample_rx = 1'b1;
          if (sclk_fall) begin
            if (bit_cnt != 3'd0) shift_tx = 1'b1;
            else                 load_tx  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter, MISO and the one-cycle-delayed FIFO push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift     <= 8'h00;
      rx_shift     <= 8'h00;
      bit_cnt      <= 3'd0;
      spi_miso     <= 1'b0;
      push_pending <= 1'b0;
      push_data    <= 8'h00;
    end else begin
      push_pending <= 1'b0;
      if (load_tx) begin
        tx_shift <= tx_full ? tx_hold : 8'h00;
        spi_miso <= tx_full & tx_hold[7];
      end
      if (shift_tx) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
        spi_miso <= tx_shift[6];
      end
      if (sample_rx) begin
        rx_shift <= {rx_shift[6:0], mosi_sync};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          push_pending <= 1'b1;
          push_data    <= {rx_shift[6:0], mosi_sync};
        end
      end
      if (end_xfer) begin
        bit_cnt  <= 3'd0;
        spi_miso <= 1'b0;
      end
    end
  end

  // TX holding register and sticky flags; a set in the same cycle beats a W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_hold     <= 8'h00;
      tx_full     <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (load_tx) tx_full <= 1'b0;
      if (tx_wr) begin
        tx_hold <= bus.write_value_in[7:0];
        tx_full <= 1'b1;
      end
      if (ctrl_wr && bus.write_value_in[0]) rx_overrun  <= 1'b0;
      if (ctrl_wr && bus.write_value_in[1]) tx_underrun <= 1'b0;
      if (load_tx && !tx_full) tx_underrun <= 1'b1;
      if (overrun_evt) rx_overrun <= 1'b1;
    end
  end

  // RX FIFO; a same-cycle pop frees the slot so a push into a full FIFO still lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_rd_prev <= 1'b0;
    end else begin
      rx_rd_prev <= rx_rd;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop)      count <= count + CNT_ONE;
      else if (!push_ok && pop) count <= count - CNT_ONE;
    end
  end

`ifdef SPI_TARGET_IRQ_EN
  // Interrupt enables live in CTRL[3:2]; the interrupt output is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en <= 2'b00;
      irq_out <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_en <= bus.write_value_in[3:2];
      irq_out <= (rx_valid & ctrl_en[0]) | ((rx_overrun | tx_underrun) & ctrl_en[1]);
    end
  end
`endif

  // Combinational read mux, zero whenever the bus is not reading.
  always_comb begin
    read_value = 32'h0;
    if (rd_sel) begin
      case (offset)
        4'h0:    read_value = {24'h0, rx_head};
        4'h8:    read_value = {27'h0, tx_underrun, rx_overrun, rx_full, rx_valid, active};
`ifdef SPI_TARGET_IRQ_EN
        4'hC:    read_value = {28'h0, ctrl_en, 2'b00};
`endif
        default: read_value = 32'h0;
      endcase
    end
  end

  assign bus.read_value_out = read_value;
  assign bus.ready_out      = bus.sel_in;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed self-checking bench for spi_target (SCLK = clk/64, mode 0).
module tb_spi_target;
  localparam int HALF = 32;

  logic clk = 1'b0;
  logic reset_n;
  logic spi_clk, spi_mosi, spi_cs_n;
  logic spi_miso;
`ifdef SPI_TARGET_IRQ_EN
  logic irq_out;
`endif

  int nassert = 0;
  int nfail   = 0;

  spi_target_if bus();

  spi_target #(.SYNC_STAGES(2), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_cs_n (spi_cs_n),
    .spi_miso (spi_miso)
`ifdef SPI_TARGET_IRQ_EN
    ,
    .irq_out  (irq_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.sel_in         = 1'b0;
    bus.read_in        = 1'b0;
    bus.address_in     = 32'h0;
    bus.write_mask_in  = 4'h0;
    bus.write_value_in = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.sel_in = 1'b1; bus.read_in = 1'b0; bus.address_in = addr;
    bus.write_mask_in = 4'hF; bus.write_value_in = data;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] addr, input int hold, output logic [31:0] data);
    @(negedge clk);
    bus.sel_in = 1'b1; bus.read_in = 1'b1; bus.address_in = addr; bus.write_mask_in = 4'h0;
    #1 data = bus.read_value_out;
    repeat (hold) @(negedge clk);
    bus_idle();
  endtask

  task automatic spi_begin();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Clocks nbits bits out MSB first; with last set, SCLK is left high after the final rise.
  task automatic spi_bits(input logic [7:0] mosi_b, input int nbits, input bit last,
                          output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_b[7-i];
      repeat (HALF) @(negedge clk);
      miso_b = {miso_b[6:0], spi_miso};
      spi_clk = 1'b1;
      if (!(last && i == nbits - 1)) begin
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
      end
    end
  endtask

  // Final SCLK fall and CS rise hit the pins together, so no byte-boundary reload happens.
  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #1;
    nassert++; if (spi_miso !== 1'b0) begin nfail++; $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso); end
    bus.sel_in = 1'b1; bus.read_in = 1'b1; bus.address_in = 32'h8;
    #1;
    nassert++; if (bus.read_value_out !== 32'h0) begin nfail++; $display("[TB] FAIL reset_status: got %h expected 0", bus.read_value_out); end
    nassert++; if (bus.ready_out !== 1'b1) begin nfail++; $display("[TB] FAIL ready_sel: got %b expected 1", bus.ready_out); end
    bus_idle();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(32'h0, 1, rd);
    nassert++; if (rd !== 32'h0) begin nfail++; $display("[TB] FAIL reset_rxdata: got %h expected 0", rd); end
    bus_write(32'hC, 32'hC);
    bus_read(32'hC, 1, rd);
`ifdef SPI_TARGET_IRQ_EN
    nassert++; if (rd !== 32'hC) begin nfail++; $display("[TB] FAIL ctrl_readback: got %h expected c", rd); end
`else
    nassert++; if (rd !== 32'h0) begin nfail++; $display("[TB] FAIL ctrl_readback: got %h expected 0", rd); end
`endif
    bus_write(32'hC, 32'h0);
  endtask

  task automatic test_rx_basic();
    logic [31:0] rd;
    logic [7:0]  mb;
    spi_begin();
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h11) begin nfail++; $display("[TB] FAIL active_status: got %h expected 11", rd); end
    spi_bits(8'hA5, 8, 1'b1, mb);
    bus.sel_in = 1'b1; bus.read_in = 1'b1; bus.address_in = 32'h8;
    repeat (3) @(posedge clk);
    #1;
    nassert++; if (bus.read_value_out[1] !== 1'b0) begin nfail++; $display("[TB] FAIL latency_early: got %b expected 0", bus.read_value_out[1]); end
    @(posedge clk);
    #1;
    nassert++; if (bus.read_value_out[1] !== 1'b1) begin nfail++; $display("[TB] FAIL latency_valid: got %b expected 1", bus.read_value_out[1]); end
    bus_idle();
    spi_end();
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h12) begin nfail++; $display("[TB] FAIL rx_status: got %h expected 12", rd); end
    bus_read(32'h0, 1, rd);
    nassert++; if (rd !== 32'hA5) begin nfail++; $display("[TB] FAIL rx_data: got %h expected a5", rd); end
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h10) begin nfail++; $display("[TB] FAIL rx_drained: got %h expected 10", rd); end
    bus_write(32'hC, 32'h2);
  endtask

  task automatic test_tx_preload();
    logic [31:0] rd;
    logic [7:0]  mb;
    bus_write(32'h4, 32'h0000_003C);
    spi_begin();
    spi_bits(8'h00, 8, 1'b1, mb);
    spi_end();
    nassert++; if (mb !== 8'h3C) begin nfail++; $display("[TB] FAIL tx_miso: got %h expected 3c", mb); end
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h02) begin nfail++; $display("[TB] FAIL tx_status: got %h expected 02", rd); end
    bus_read(32'h0, 1, rd);
    nassert++; if (rd !== 32'h00) begin nfail++; $display("[TB] FAIL tx_rxbyte: got %h expected 00", rd); end
  endtask

  task automatic test_back_to_back_underrun();
    logic [31:0] rd;
    logic [7:0]  m1, m2;
    spi_begin();
    spi_bits(8'h11, 8, 1'b0, m1);
    spi_bits(8'h22, 8, 1'b1, m2);
    spi_end();
    nassert++; if (m1 !== 8'h00) begin nfail++; $display("[TB] FAIL b2b_miso0: got %h expected 00", m1); end
    nassert++; if (m2 !== 8'h00) begin nfail++; $display("[TB] FAIL b2b_miso1: got %h expected 00", m2); end
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h12) begin nfail++; $display("[TB] FAIL b2b_status: got %h expected 12", rd); end
    bus_read(32'h0, 1, rd);
    nassert++; if (rd !== 32'h11) begin nfail++; $display("[TB] FAIL b2b_byte0: got %h expected 11", rd); end
    bus_read(32'h0, 1, rd);
    nassert++; if (rd !== 32'h22) begin nfail++; $display("[TB] FAIL b2b_byte1: got %h expected 22", rd); end
    bus_write(32'hC, 32'h1);
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h10) begin nfail++; $display("[TB] FAIL w1c_wrongbit: got %h expected 10", rd); end
    bus_write(32'hC, 32'h2);
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h00) begin nfail++; $display("[TB] FAIL w1c_underrun: got %h expected 00", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [7:0]  mb;
    logic [7:0]  exp_bytes [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    spi_begin();
    for (int b = 1; b <= 5; b++) spi_bits(8'(b), 8, b == 5, mb);
    spi_end();
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h1E) begin nfail++; $display("[TB] FAIL ovf_status: got %h expected 1e", rd); end
    for (int k = 0; k < 5; k++) begin
      bus_read(32'h0, (k == 0) ? 3 : 1, rd);
      nassert++; if (rd !== {24'h0, exp_bytes[k]}) begin nfail++; $display("[TB] FAIL ovf_read%0d: got %h expected %h", k, rd, exp_bytes[k]); end
    end
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h18) begin nfail++; $display("[TB] FAIL ovf_sticky: got %h expected 18", rd); end
    bus_write(32'hC, 32'h3);
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h00) begin nfail++; $display("[TB] FAIL ovf_clear: got %h expected 00", rd); end
  endtask

  task automatic test_partial_abort();
    logic [31:0] rd;
    logic [7:0]  mb;
    spi_begin();
    spi_bits(8'hFF, 5, 1'b1, mb);
    spi_end();
    nassert++; if (spi_miso !== 1'b0) begin nfail++; $display("[TB] FAIL abort_miso: got %b expected 0", spi_miso); end
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h10) begin nfail++; $display("[TB] FAIL abort_status: got %h expected 10", rd); end
    spi_begin();
    spi_bits(8'h81, 8, 1'b1, mb);
    spi_end();
    bus_read(32'h0, 1, rd);
    nassert++; if (rd !== 32'h81) begin nfail++; $display("[TB] FAIL abort_next: got %h expected 81", rd); end
    bus_write(32'hC, 32'h3);
  endtask

  task automatic test_reset_mid_byte();
    logic [31:0] rd;
    logic [7:0]  mb;
    bus_write(32'h4, 32'hF0);
    spi_begin();
    nassert++; if (spi_miso !== 1'b1) begin nfail++; $display("[TB] FAIL midrst_miso_pre: got %b expected 1", spi_miso); end
    spi_bits(8'hFF, 3, 1'b1, mb);
    bus.sel_in = 1'b1; bus.read_in = 1'b1; bus.address_in = 32'h8;
    @(negedge clk);
    nassert++; if (bus.read_value_out !== 32'h01) begin nfail++; $display("[TB] FAIL midrst_status_pre: got %h expected 01", bus.read_value_out); end
    reset_n = 1'b0;
    #1;
    nassert++; if (spi_miso !== 1'b0) begin nfail++; $display("[TB] FAIL midrst_miso: got %b expected 0", spi_miso); end
    nassert++; if (bus.read_value_out !== 32'h0) begin nfail++; $display("[TB] FAIL midrst_status: got %h expected 0", bus.read_value_out); end
    bus_idle();
    spi_clk = 1'b0; spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_begin();
    spi_bits(8'h5A, 8, 1'b1, mb);
    spi_end();
    bus_read(32'h8, 1, rd);
    nassert++; if (rd !== 32'h12) begin nfail++; $display("[TB] FAIL midrst_after_status: got %h expected 12", rd); end
    bus_read(32'h0, 1, rd);
    nassert++; if (rd !== 32'h5A) begin nfail++; $display("[TB] FAIL midrst_after_data: got %h expected 5a", rd); end
    bus_write(32'hC, 32'h3);
  endtask

`ifdef SPI_TARGET_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd;
    logic [7:0]  mb;
    spi_begin();
    spi_bits(8'h77, 8, 1'b1, mb);
    spi_end();
    bus_write(32'hC, 32'h8);
    @(posedge clk); #1;
    nassert++; if (irq_out !== 1'b1) begin nfail++; $display("[TB] FAIL irq_err: got %b expected 1", irq_out); end
    bus_write(32'hC, 32'h2);
    @(posedge clk); #1;
    nassert++; if (irq_out !== 1'b0) begin nfail++; $display("[TB] FAIL irq_off: got %b expected 0", irq_out); end
    bus_write(32'hC, 32'h4);
    @(posedge clk); #1;
    nassert++; if (irq_out !== 1'b1) begin nfail++; $display("[TB] FAIL irq_rx: got %b expected 1", irq_out); end
    bus_read(32'h0, 1, rd);
    bus_write(32'hC, 32'h0);
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    bus_idle();
    $display("[TB] start");
    test_reset();
    test_rx_basic();
    test_tx_preload();
    test_back_to_back_underrun();
    test_overflow();
    test_partial_abort();
    test_reset_mid_byte();
`ifdef SPI_TARGET_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
